// File: rtl/multdiv_pkg.sv
// Shared types and sizing constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the Booth step and the trial subtraction.
module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider, one step per cycle.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int              CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   mcand;
    logic               neg_quot;
    logic               div_zero;
    logic               div_ovf;

    logic               accept;
    logic               start_mul;
    logic               start_div;
    logic               last_step;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     add_y;
    logic               add_sub;
    logic [WIDTH:0]     booth_mix;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   div_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   quot;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     product_top;

    assign accept    = (state == IDLE) || (state == DONE);
    assign start_mul = accept && ctrl_MULT;
    assign start_div = accept && ctrl_DIV && !ctrl_MULT;
    assign last_step = (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_mul) begin
                    state_next = MUL;
                end else if (start_div) begin
                    state_next = DIV;
                end else begin
                    state_next = IDLE;
                end
            end
            MUL, DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_resultRDY = (state == DONE);
    end

    // prod holds {acc, multiplier, q-1} for MUL and {remainder, quotient, 0} for DIV.
    always_comb begin
        add_a   = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        add_b   = {mcand[WIDTH-1], mcand};
        add_sub = (prod[1:0] == 2'b10);
        if (state == DIV) begin
            add_a   = prod[2*WIDTH:WIDTH];
            add_b   = {1'b0, mcand};
            add_sub = 1'b1;
        end
    end

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    // The add result is one bit wider, so the arithmetic shift just drops its LSB into the multiplier.
    assign booth_mix   = (prod[1] ^ prod[0]) ? add_y : add_a;
    assign mul_next    = {booth_mix, prod[WIDTH:1]};
    assign product     = mul_next[2*WIDTH:1];
    assign product_top = product[2*WIDTH-1:WIDTH-1];

    assign rem_next = add_y[WIDTH] ? prod[2*WIDTH-1:WIDTH] : add_y[WIDTH-1:0];
    assign div_next = {rem_next, prod[WIDTH-1:1], ~add_y[WIDTH], 1'b0};
    assign quot     = div_next[WIDTH:1];

    assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            prod           <= '0;
            mcand          <= '0;
            neg_quot       <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mul) begin
            cnt   <= '0;
            prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand <= data_operandA;
        end else if (start_div) begin
            cnt      <= '0;
            prod     <= {{WIDTH{1'b0}}, a_abs, 1'b0};
            mcand    <= b_abs;
            neg_quot <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
        end else if (state == MUL) begin
            cnt  <= cnt + CW'(1);
            prod <= mul_next;
            if (last_step) begin
                data_result    <= product[WIDTH-1:0];
                data_exception <= !((&product_top) || !(|product_top));
            end
        end else if (state == DIV) begin
            cnt  <= cnt + CW'(1);
            prod <= div_next;
            if (last_step) begin
                data_result    <= div_zero ? '0 : (neg_quot ? -quot : quot);
                data_exception <= div_zero || div_ovf;
            end
        end
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative 32-bit signed multiply/divide unit that sits directly downstream of the processor's execute stage inside `skeleton`. The execute stage issues a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse with operands, stalls, and waits for `data_resultRDY`. The result is then written back like any ALU result. Overflow and divide-by-zero are reported on `data_exception` so the processor can write the exception code to `$rstatus`.

## Interface
- `WIDTH`, default 32: operand, result and iteration-count width.
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `ctrl_MULT`, input, 1: start a signed multiply; sampled on a rising edge.
- `ctrl_DIV`, input, 1: start a signed divide; sampled on a rising edge.
- `data_operandA`, input, WIDTH: multiplicand or dividend; sampled with the start.
- `data_operandB`, input, WIDTH: multiplier or divisor; sampled with the start.
- `data_result`, output, WIDTH: product low word or quotient; held until the next start.
- `data_exception`, output, 1: the result is invalid or overflowed; meaningful while `data_resultRDY` is high and held afterwards.
- `data_resultRDY`, output, 1: one-cycle pulse marking a completed operation.

## Operation
- **FSM states:** IDLE, MUL, DIV, DONE.
- **Reset value:** IDLE; `data_result`=0, `data_exception`=0, `data_resultRDY`=0, iteration counter=0.
- **Start acceptance:** starts are accepted only in IDLE or DONE, so back-to-back operations are allowed.
  - `ctrl_MULT` moves the FSM to MUL.
  - `ctrl_DIV` moves the FSM to DIV.
  - If both are high, MULT wins and DIV is dropped.
  - Start pulses while in MUL or DIV are ignored; operands are not re-sampled.
- **Multiply:** radix-2 Booth algorithm on a (2·WIDTH+1)-bit product/multiplier register, one step per cycle, WIDTH steps.
  - `data_result` = low WIDTH bits of the 2·WIDTH-bit product.
  - `data_exception` = 1 when the upper WIDTH+1 bits of the product are not all equal, i.e. the result does not fit signed WIDTH. The truncated low word is still output in this case.
- **Divide:** restoring division on operand magnitudes, one quotient bit per cycle, WIDTH steps, then sign correction.
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor = 0: `data_exception`=1, `data_result`=0. The operation still takes the full latency.
  - Dividend = −2^(WIDTH−1) and divisor = −1: `data_exception`=1, `data_result`=0x80000000.
- **DONE:** `data_resultRDY`=1 for exactly this one cycle. Next state is IDLE, or MUL/DIV if a new start is sampled.
- **Reset mid-operation:** aborts immediately and returns the block to its reset values. No `data_resultRDY` pulse is produced for the aborted operation.

## Timing
- A start sampled at rising edge N loads the operands and enters MUL or DIV.
- Edges N+1 … N+WIDTH perform the WIDTH iterations. The edge at N+WIDTH also registers the final result and exception and enters DONE.
- `data_resultRDY` is high between edges N+WIDTH and N+WIDTH+1. Latency is WIDTH cycles (32) from the start edge.
- In a back-to-back case, a start sampled in DONE at edge N+WIDTH+1 begins the next operation. Its result is ready after edge N+2·WIDTH+1.
- Outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `multdiv_pkg` holds:
  - the FSM state enum (IDLE/MUL/DIV/DONE);
  - the `WIDTH` default;
  - the counter-width constant `$clog2(WIDTH)+1`.
- One sub-module, `multdiv_addsub`: a WIDTH+1-bit adder/subtractor with a `sub` select. It is shared by the Booth add/subtract step and the restoring-divide trial subtraction; only one operation is in flight at a time.
- Top level contains the FSM, counter, product/accumulator registers and sign/exception logic.

## Test plan
- MULT 6 × 7 → `data_resultRDY` pulses exactly 32 cycles after the start edge; `data_result`=42, `data_exception`=0. `data_resultRDY` is low on every other cycle.
- MULT −3 × 5 → 0xFFFFFFF1, exception 0. MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
- DIV 100 ÷ −7 → 0xFFFFFFF2 (−14), exception 0. DIV 5 ÷ 0 → result 0, exception 1, still 32-cycle latency.
- DIV 0x80000000 ÷ 0xFFFFFFFF → result 0x80000000, exception 1.
- Start a MULT, then at cycle 10 pulse `ctrl_DIV` with different operands → the DIV is ignored and the original product is returned.
- Start a DIV, then at cycle 10 assert `reset` → outputs are 0 immediately and no `data_resultRDY` follows. A MULT 2×3 after release returns 6. A second MULT issued in the DONE cycle completes 32 cycles later.
